// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
//
// Purpose:
//   Takes one instruction-encode request at a time (R / LD / SD / BEQ / ADDI)
//   and turns it into a 32-bit RV64I instruction word. The word is then written
//   into an instruction memory at the next free word address. Illegal request
//   types set a sticky error flag and write nothing. Once DEPTH words have been
//   written the block parks in FULL until a clear or a reset.
//
//   Sequence per request:  IDLE --accept--> ENCODE --> WRITE --> IDLE/FULL
//   The imem_we strobe is high during the WRITE cycle, which is the second
//   cycle after the acceptance cycle.
//
// Optional feature (macro ENCODER_NOP_PAD_EN):
//   When defined, every BEQ write is followed by a NOP (0x00000013) at the next
//   address, written from an extra PAD state. The NOP is skipped if the BEQ
//   write filled the memory. The NOP counts toward count.
//   When undefined, the PAD state does not exist and no padding is written.
//
// Parameters:
//   DEPTH   number of writable instruction words (DEPTH <= 2**ADDR_W)
//   ADDR_W  instruction-memory word address width
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   clear        synchronous restart: back to IDLE, count=0, err=0
//   req_valid    encode request present
//   req_ready    high only in IDLE; a request is taken on req_valid & req_ready
//   req_type     0=R, 1=LD, 2=SD, 3=BEQ, 4=ADDI, 5-7 illegal
//   req_funct    R-type {funct7[5], funct3}
//   req_rd       destination register index
//   req_rs1      source register 1 index
//   req_rs2      source register 2 index
//   req_imm      imm[11:0]; for BEQ it is the byte offset bits imm[12:1]
//   imem_we      one-cycle write strobe
//   imem_addr    word address of the write
//   imem_wdata   encoded instruction word
//   count        number of words written
//   full         count == DEPTH
//   err          sticky illegal-type flag
// -----------------------------------------------------------------------------
module instr_encoder_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_type,
  input  logic [3:0]        req_funct,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [11:0]       req_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  // RV64I major opcodes
  localparam logic [6:0]  OP_REG    = 7'b0110011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [2:0]  F3_DWORD  = 3'b011;
  localparam logic [2:0]  F3_ZERO   = 3'b000;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    T_R    = 3'd0,
    T_LD   = 3'd1,
    T_SD   = 3'd2,
    T_BEQ  = 3'd3,
    T_ADDI = 3'd4
  } rtype_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENCODE,
    S_WRITE,
    S_FULL
`ifdef ENCODER_NOP_PAD_EN
    , S_PAD
`endif
  } state_t;

  typedef struct packed {
    logic [2:0]  rtype;
    logic [3:0]  funct;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
  } req_t;

  state_t          state;
  req_t            req_q;
  logic [31:0]     enc_word;
  logic            enc_legal;
  logic [ADDR_W:0] count_inc;

  assign count_inc = count + 1'b1;
  assign full      = (count == DEPTH_C);

  // Encoder works on the latched request so the request bus is free to
  // change as soon as the handshake completes.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (rtype_t'(req_q.rtype))
      T_R:    enc_word = {1'b0, req_q.funct[3], 5'b00000, req_q.rs2, req_q.rs1,
                          req_q.funct[2:0], req_q.rd, OP_REG};
      T_LD:   enc_word = {req_q.imm, req_q.rs1, F3_DWORD, req_q.rd, OP_LOAD};
      T_SD:   enc_word = {req_q.imm[11:5], req_q.rs2, req_q.rs1, F3_DWORD,
                          req_q.imm[4:0], OP_STORE};
      // req_q.imm holds offset[12:1]: offset[12]=imm[11], offset[11]=imm[10],
      // offset[10:5]=imm[9:4], offset[4:1]=imm[3:0].
      T_BEQ:  enc_word = {req_q.imm[11], req_q.imm[9:4], req_q.rs2, req_q.rs1,
                          F3_ZERO, req_q.imm[3:0], req_q.imm[10], OP_BRANCH};
      T_ADDI: enc_word = {req_q.imm, req_q.rs1, F3_ZERO, req_q.rd, OP_IMM};
      default: enc_legal = 1'b0;
    endcase
  end

  // Single FSM process; all outputs are registered. req_ready is set on every
  // transition into IDLE so it is high exactly while the FSM sits in IDLE.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the latched request and write data are reset too; they drive
      // outputs directly and must read as zero while reset is held.
      state      <= S_IDLE;
      req_q      <= '0;
      count      <= '0;
      err        <= 1'b0;
      req_ready  <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else if (clear) begin
      // A strobe already on the outputs finishes this cycle; count is zeroed
      // rather than incremented. Address/data stay as they were.
      state     <= S_IDLE;
      count     <= '0;
      err       <= 1'b0;
      req_ready <= 1'b1;
      imem_we   <= 1'b0;
    end else begin
      imem_we   <= 1'b0;
      req_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_q <= '{rtype: req_type, funct: req_funct, rd: req_rd,
                       rs1: req_rs1, rs2: req_rs2, imm: req_imm};
            state <= S_ENCODE;
          end else begin
            req_ready <= 1'b1;
          end
        end

        S_ENCODE: begin
          if (enc_legal) begin
            imem_we    <= 1'b1;
            imem_addr  <= count[ADDR_W-1:0];
            imem_wdata <= enc_word;
            state      <= S_WRITE;
          end else begin
            err       <= 1'b1;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

        S_WRITE: begin
          count <= count_inc;
`ifdef ENCODER_NOP_PAD_EN
          if (req_q.rtype == T_BEQ && count_inc != DEPTH_C) begin
            imem_we    <= 1'b1;
            imem_addr  <= count_inc[ADDR_W-1:0];
            imem_wdata <= NOP_WORD;
            state      <= S_PAD;
          end else
`endif
          if (count_inc == DEPTH_C) begin
            state <= S_FULL;
          end else begin
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

`ifdef ENCODER_NOP_PAD_EN
        S_PAD: begin
          count <= count_inc;
          if (count_inc == DEPTH_C) begin
            state <= S_FULL;
          end else begin
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
`endif

        // Parked until clear or reset; req_ready stays low.
        S_FULL: state <= S_FULL;

        default: begin
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder_loader
//
// Self-checking bench for instr_encoder_loader (DEPTH=4, ADDR_W=2).
// A reference model keeps the expected write list, word count and error flag,
// computing instruction words arithmetically from the RV64I field layout.
// A monitor compares every imem_we strobe against the expected write list.
// Directed cases cover reset, the R/LD/BEQ reference vectors, fill-to-full,
// illegal type, clear during a write and reset during a write. These are
// followed by randomized requests.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_encoder_loader;

  localparam int          DEPTH  = 4;
  localparam int          ADDR_W = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [2:0]        req_type = '0;
  logic [3:0]        req_funct = '0;
  logic [4:0]        req_rd = '0;
  logic [4:0]        req_rs1 = '0;
  logic [4:0]        req_rs2 = '0;
  logic [11:0]       req_imm = '0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_funct(req_funct),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  m_count = 0;
  bit  m_err   = 1'b0;

`ifdef ENCODER_NOP_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Instruction word from the RV64I field positions, built with plain arithmetic.
  function automatic logic [31:0] model_word(input int t, input int f, input int rd,
                                             input int rs1, input int rs2, input int imm);
    logic [31:0] w;
    int off;
    w = 0;
    case (t)
      0: w = (((f >> 3) & 1) << 30) + (rs2 << 20) + (rs1 << 15) + ((f & 7) << 12) + (rd << 7) + 'h33;
      1: w = (imm << 20) + (rs1 << 15) + (3 << 12) + (rd << 7) + 'h03;
      2: w = ((imm >> 5) << 25) + (rs2 << 20) + (rs1 << 15) + (3 << 12) + ((imm & 31) << 7) + 'h23;
      3: begin
        off = imm * 2;
        w = (((off >> 12) & 1) << 31) + (((off >> 5) & 63) << 25) + (rs2 << 20) + (rs1 << 15)
          + (((off >> 1) & 15) << 8) + (((off >> 11) & 1) << 7) + 'h63;
      end
      4: w = (imm << 20) + (rs1 << 15) + (rd << 7) + 'h13;
      default: w = 0;
    endcase
    return w;
  endfunction

  function automatic void model_accept(input int t, input int f, input int rd,
                                       input int rs1, input int rs2, input int imm);
    if (t > 4) begin
      m_err = 1'b1;
    end else if (m_count < DEPTH) begin
      exp_q.push_back('{m_count, model_word(t, f, rd, rs1, rs2, imm)});
      m_count++;
      if (PAD && t == 3 && m_count < DEPTH) begin
        exp_q.push_back('{m_count, NOP});
        m_count++;
      end
    end
  endfunction

  // Every strobe must match the head of the expected write list.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && imem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'(imem_we), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(e.addr));
        check("wr_data", imem_wdata, e.data);
      end
    end
  end

  // Returns at the falling edge after the acceptance clock edge.
  task automatic send(input int t, input int f, input int rd, input int rs1,
                      input int rs2, input int imm, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_type  = 3'(t);
    req_funct = 4'(f);
    req_rd    = 5'(rd);
    req_rs1   = 5'(rs1);
    req_rs2   = 5'(rs2);
    req_imm   = 12'(imm);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready;
    if (!ok) begin
      check("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(t, f, rd, rs1, rs2, imm);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_we(output bit ok);
    int n;
    n = 0;
    while (!imem_we && n < 10) begin
      @(negedge clk);
      n++;
    end
    ok = imem_we;
    if (!ok) check("we_timeout", 32'(imem_we), 32'd1);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  task automatic check_state(input string pfx);
    check({pfx, "_count"}, 32'(count), 32'(m_count));
    check({pfx, "_err"},   32'(err),   32'(m_err));
    check({pfx, "_full"},  32'(full),  32'(m_count == DEPTH));
    check({pfx, "_ready"}, 32'(req_ready), 32'(m_count != DEPTH));
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_count = 0;
    m_err   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int t;

    // Reset held: every output at its reset value.
    #12;
    check("rst_we",    32'(imem_we),    32'd0);
    check("rst_addr",  32'(imem_addr),  32'd0);
    check("rst_wdata", imem_wdata,      32'd0);
    check("rst_count", 32'(count),      32'd0);
    check("rst_ready", 32'(req_ready),  32'd0);
    check("rst_err",   32'(err),        32'd0);
    check("rst_full",  32'(full),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready), 32'd1);

    // R-type reference vector with the exact strobe latency.
    send(0, 0, 3, 1, 2, 0, ok);
    check("r_encode_we",    32'(imem_we),   32'd0);
    check("r_encode_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("r_we",   32'(imem_we),   32'd1);
    check("r_addr", 32'(imem_addr), 32'd0);
    check("r_data", imem_wdata,     32'h002081B3);
    @(negedge clk);
    check("r_we_drop", 32'(imem_we), 32'd0);
    settle();
    check_state("r");

    // LD reference vector.
    send(1, 0, 5, 10, 0, 8, ok);
    wait_we(ok);
    check("ld_addr", 32'(imem_addr), 32'd1);
    check("ld_data", imem_wdata,     32'h00853283);
    settle();
    check_state("ld");

    // BEQ reference vector (negative offset).
    send(3, 0, 0, 1, 2, 'hFFC, ok);
    wait_we(ok);
    check("beq_addr", 32'(imem_addr), 32'd2);
    check("beq_data", imem_wdata,     32'hFE208CE3);
`ifdef ENCODER_NOP_PAD_EN
    @(negedge clk);
    check("pad_we",   32'(imem_we),   32'd1);
    check("pad_addr", 32'(imem_addr), 32'd3);
    check("pad_data", imem_wdata,     NOP);
`endif
    settle();
    check_state("beq");

    // Fill up, then hold a request against a full memory.
    if (m_count < DEPTH) begin
      send(2, 0, 0, 3, 4, 'h7E5, ok);
      settle();
    end
    check_state("fill");
    @(negedge clk);
    req_valid = 1'b1;
    req_type  = 3'd4;
    repeat (10) @(negedge clk);
    check("full_hold_ready", 32'(req_ready), 32'd0);
    check("full_hold_count", 32'(count),     32'(DEPTH));
    req_valid = 1'b0;
    do_clear();
    check_state("full_clear");

    // Illegal type: error flag, no write, count unchanged.
    send(4, 0, 7, 8, 0, 'h123, ok);
    settle();
    send(6, 0, 1, 2, 3, 'h456, ok);
    settle();
    check_state("illegal");
    do_clear();
    check_state("illegal_clear");

    // Clear while the strobe is on the outputs: count goes to 0, not 1.
    send(4, 0, 9, 10, 0, 'h0AA, ok);
    wait_we(ok);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_count = 0;
    m_err   = 1'b0;
    check("clr_wr_we",    32'(imem_we), 32'd0);
    check("clr_wr_count", 32'(count),   32'd0);
    settle();
    check_state("clr_wr");

    // Reset during a write: strobe drops at once and never reappears.
    send(2, 0, 0, 5, 6, 'h3C3, ok);
    wait_we(ok);
    #2 rst_n = 1'b0;
    #1;
    check("rst_wr_we",    32'(imem_we),   32'd0);
    check("rst_wr_addr",  32'(imem_addr), 32'd0);
    check("rst_wr_wdata", imem_wdata,     32'd0);
    check("rst_wr_count", 32'(count),     32'd0);
    check("rst_wr_ready", 32'(req_ready), 32'd0);
    m_count = 0;
    m_err   = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_wr_ready_rise", 32'(req_ready), 32'd1);
    settle();
    check_state("rst_wr");

    // Randomized requests against the model.
    for (int i = 0; i < 60; i++) begin
      if (m_count == DEPTH || $urandom_range(0, 9) == 0) begin
        do_clear();
        check_state("rnd_clear");
      end
      t = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 4) : $urandom_range(5, 7);
      send(t, $urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 4095), ok);
      settle();
      check_state("rnd");
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64, instruction-memory words writable.
REQ-002 SHALL have parameter ADDR_W, default 6, imem address width, with DEPTH <= 2**ADDR_W.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port clear  input  1  synchronous restart of the load sequence.
REQ-007 SHALL have port req_valid  input  1  encode request present.
REQ-008 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-009 SHALL have port req_type  input  3  0=R, 1=LD, 2=SD, 3=BEQ, 4=ADDI, 5-7 illegal.
REQ-010 SHALL have port req_funct  input  4  R-type {funct7[5], funct3}.
REQ-011 SHALL have ports req_rd, req_rs1 and req_rs2  input  5 each  register indices.
REQ-012 SHALL have port req_imm  input  12  imm[11:0]; for BEQ, byte offset imm[12:1].
REQ-013 SHALL have port imem_we  output  1  one-cycle write strobe.
REQ-014 SHALL have port imem_addr  output  ADDR_W  word address.
REQ-015 SHALL have port imem_wdata  output  32  encoded instruction.
REQ-016 SHALL have port count  output  ADDR_W+1  words written.
REQ-017 SHALL have ports full and err  output  1 each  count==DEPTH and sticky illegal-type flag.

Function
REQ-018 SHALL implement FSM IDLE -> ENCODE -> WRITE -> IDLE, plus FULL.
REQ-019 SHALL drive req_ready high only in IDLE.
REQ-020 SHALL accept a request on req_valid & req_ready, latching all req_* fields.
REQ-021 SHALL register the encoded word in ENCODE.
REQ-022 SHALL assert registered imem_we for exactly one cycle in WRITE, with imem_addr=count, then increment count; first strobe 2 cycles after acceptance.
REQ-023 SHALL encode per RV64I opcodes: R 0110011, funct7={0,req_funct[3],00000}; LD 0000011 funct3=011; SD 0100011 funct3=011 with split imm; BEQ 1100011 funct3=000 with B-format scatter; ADDI 0010011 funct3=000.
REQ-024 SHALL, for an illegal req_type, complete the handshake, set err, skip WRITE, leave count unchanged and return to IDLE.
REQ-025 SHALL enter FULL after the write making count==DEPTH; FULL holds req_ready low and exits only on clear or reset.
REQ-026 SHALL make clear take priority in every state: next state IDLE, count=0, err=0. A WRITE strobe already on the outputs completes, but count is not incremented.
REQ-027 SHALL hold imem_wdata and imem_addr stable outside WRITE.

Reset
REQ-028 SHALL, while rst_n is low, force IDLE, count=0, imem_we=0, imem_addr=0, imem_wdata=0, err=0, full=0 and req_ready=0, asynchronously.
REQ-029 SHALL abort any in-flight write immediately on reset; no strobe is issued after deassertion.
REQ-030 SHALL allow req_ready to rise on the first clock edge after rst_n deasserts.

Configuration
REQ-031 SHALL recognise the macro ENCODER_NOP_PAD_EN.
REQ-032 SHALL, when ENCODER_NOP_PAD_EN is defined, write one NOP 0x00000013 at the next address after every BEQ write via an extra PAD state. The NOP is not written if count reaches DEPTH first. The NOP counts toward count.
REQ-033 SHALL, when ENCODER_NOP_PAD_EN is undefined, exclude the PAD state and insert no padding.

Verification
REQ-034 SHALL test reset: rst_n=0 mid-WRITE -> imem_we=0 at once; after release count=0, req_ready=1.
REQ-035 SHALL test R-type: type 0, funct 0, rd 3, rs1 1, rs2 2 -> imem_wdata 0x002081B3 at addr 0, 2 cycles after accept.
REQ-036 SHALL test LD: type 1, imm 8, rs1 10, rd 5 -> 0x00853283 at addr 1; count=2.
REQ-037 SHALL test BEQ: type 3, rs1 1, rs2 2, req_imm 0xFFC -> 0xFE208CE3. With ENCODER_NOP_PAD_EN, 0x00000013 follows at the next address.
REQ-038 SHALL test full: DEPTH=4, 4 writes -> full=1, req_ready=0, a held 5th request is not accepted; clear -> count=0, req_ready=1.
REQ-039 SHALL test illegal: type 6 -> err=1, no imem_we, count unchanged; clear -> err=0.
